// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_pkg
//  Brief    : Shared types, key codes and helpers for the 4x4 keypad scanner
//  Revision : 1.0  initial release
// ============================================================================
package kbd_pkg;

  // Scanner FSM states
  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    DBNC_P = 2'd1,
    HOLD   = 2'd2,
    DBNC_R = 2'd3
  } kbd_state_t;

  // Result of classifying a row-sense pattern
  typedef struct packed {
    logic       valid;  // exactly one row line is low
    logic [1:0] idx;    // index of that low line
  } onehot_t;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // Physical keypad legend: row 0 is the top row, column 0 the leftmost
  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = KEY_0;
    case ({row_idx, col_idx})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_E;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_F;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

  // Accept only patterns with a single low line; anything else is idle or a ghost
  function automatic onehot_t onehot_low(input logic [3:0] rows);
    onehot_t res;
    res.valid = 1'b0;
    res.idx   = 2'd0;
    case (rows)
      4'b1110: begin res.valid = 1'b1; res.idx = 2'd0; end
      4'b1101: begin res.valid = 1'b1; res.idx = 2'd1; end
      4'b1011: begin res.valid = 1'b1; res.idx = 2'd2; end
      4'b0111: begin res.valid = 1'b1; res.idx = 2'd3; end
      default: ;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_sync2
//  Brief    : Two-flop synchronizer, resets to all ones (idle pulled-up lines)
//  Revision : 1.0  initial release
// ============================================================================
module kbd_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two register stages to settle metastability on the asynchronous inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Brief    : 4x4 keypad column scanner with press/release debounce, ghost
//             rejection and a one-cycle strobe per accepted key
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
  import kbd_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kb_row_i,
  output logic [3:0] kb_col_o,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DBNC_LAST  = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [DB_W-1:0] DBNC_SAT   = DB_W'(DEBOUNCE_CNT);

  logic [3:0]      w_row_s;
  onehot_t         w_hit;
  logic [1:0]      w_col_next_idx;
  logic [3:0]      w_col_next_drive;
  logic [DB_W-1:0] w_dbnc_inc;

  kbd_state_t      r_state;
  logic [DW_W-1:0] r_dwell;
  logic [DB_W-1:0] r_dbnc;
  logic [1:0]      r_col_idx;
  logic [3:0]      r_col_drive;
  logic [3:0]      r_pat;
  logic [1:0]      r_row_idx;
  logic [3:0]      r_code;
  logic            r_valid;
  logic            r_held;

  kbd_sync2 #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (kb_row_i),
    .o_q   (w_row_s)
  );

  assign w_hit            = onehot_low(w_row_s);
  assign w_col_next_idx   = r_col_idx + 2'd1;
  assign w_col_next_drive = ~(4'b0001 << w_col_next_idx);
  // Saturating increment so a stuck counter can never wrap into a false match
  assign w_dbnc_inc       = (r_dbnc == DBNC_SAT) ? r_dbnc : r_dbnc + DB_W'(1);

  // Scan / debounce FSM with its dwell, debounce and column registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SCAN;
      r_dwell     <= '0;
      r_dbnc      <= '0;
      r_col_idx   <= 2'd0;
      r_col_drive <= 4'b1110;
      r_pat       <= 4'hF;
      r_row_idx   <= 2'd0;
      r_code      <= KEY_0;
      r_valid     <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          // Rows only get a full sync latency to settle on the last dwell cycle
          if (r_dwell == DWELL_LAST) begin
            r_dwell <= '0;
            if (w_hit.valid) begin
              r_pat     <= w_row_s;
              r_row_idx <= w_hit.idx;
              r_dbnc    <= '0;
              r_state   <= DBNC_P;
            end else begin
              r_col_idx   <= w_col_next_idx;
              r_col_drive <= w_col_next_drive;
            end
          end else begin
            r_dwell <= r_dwell + DW_W'(1);
          end
        end
        DBNC_P: begin
          if (w_row_s != r_pat) begin
            r_state     <= SCAN;
            r_dwell     <= '0;
            r_col_idx   <= w_col_next_idx;
            r_col_drive <= w_col_next_drive;
          end else if (r_dbnc == DBNC_LAST) begin
            r_code  <= key_map(r_row_idx, r_col_idx);
            r_valid <= 1'b1;
            r_held  <= 1'b1;
            r_dbnc  <= w_dbnc_inc;
            r_state <= HOLD;
          end else begin
            r_dbnc <= w_dbnc_inc;
          end
        end
        HOLD: begin
          // Column stays frozen, so keys in other columns cannot be seen here
          if (w_row_s == 4'hF) begin
            r_dbnc  <= '0;
            r_state <= DBNC_R;
          end
        end
        DBNC_R: begin
          if (w_row_s != 4'hF) begin
            r_dbnc  <= '0;
            r_state <= HOLD;
          end else if (r_dbnc == DBNC_LAST) begin
            r_held      <= 1'b0;
            r_state     <= SCAN;
            r_dwell     <= '0;
            r_col_idx   <= w_col_next_idx;
            r_col_drive <= w_col_next_drive;
          end else begin
            r_dbnc <= w_dbnc_inc;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign kb_col_o  = r_col_drive;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule
`default_nettype wire
